cordic_serial_rot: RTL

Parametrised bit-serial CORDIC micro-rotation unit holding both X and Y accumulators. It performs one rotation step, x ± (y>>>shift) and y ∓ (x>>>shift), LSB-first over WIDTH clock cycles using one 1-bit adder/subtractor per channel. Unlike the earlier single-channel X cell, it sign-extends the shifted operand, supports any WIDTH, and has a start/busy/done handshake. It sits between the CORDIC iteration controller, which sequences shift and dir, and the angle accumulator.

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/serial_addsub.sv | 68 ++++++
 rtl/cordic_serial_rot.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the bit-serial CORDIC micro-rotation unit.
// Optional overflow detection is enabled with the CORDIC_OVF_EN macro.
package cordic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // dir encoding: DIR_ADD_X means x += y>>>i, y -= x>>>i
    localparam logic DIR_ADD_X = 1'b0;
    localparam logic DIR_SUB_X = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = clog2(WIDTH_DEF);

endpackage

// File: rtl/serial_addsub.sv
// One bit-serial accumulator channel: rotating register, registered carry, 1-bit add/sub.
// Sticky overflow detection is built only when CORDIC_OVF_EN is defined.
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             preset,
    input  logic             sub_in,
    input  logic             run,
    input  logic             last,
    input  logic             op_bit,
    output logic [WIDTH-1:0] acc,
    output logic             ovf
);

    logic sub_q;
    logic carry_q;
    logic b_bit;
    logic sum_bit;
    logic carry_out;

    always_comb begin
        b_bit     = op_bit ^ sub_q;
        sum_bit   = acc[0] ^ b_bit ^ carry_q;
        carry_out = (acc[0] & b_bit) | (carry_q & (acc[0] ^ b_bit));
    end

    // Subtraction is a + ~b + 1: the +1 comes from presetting the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (load) begin
                acc <= load_val;
            end else if (run) begin
                acc <= {sum_bit, acc[WIDTH-1:1]};
            end
            if (preset) begin
                sub_q   <= sub_in;
                carry_q <= sub_in;
            end else if (run) begin
                carry_q <= carry_out;
            end
        end
    end

`ifdef CORDIC_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
        end else if (run && last && (carry_q ^ carry_out)) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign ovf         = 1'b0;
`endif

endmodule

// File: rtl/cordic_serial_rot.sv
// Bit-serial CORDIC micro-rotation over X and Y, LSB-first across WIDTH cycles.
// Define CORDIC_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
//
// state   | meaning
// IDLE    | accumulators hold result; accept load / start
// RUN     | one bit per cycle, k = 0..WIDTH-1
module cordic_serial_rot
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic             start,
    input  logic [SHW-1:0]   shift,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             ovf
);

    localparam int             K_W    = clog2(WIDTH);
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);
    localparam logic [K_W-1:0] K_ONE  = K_W'(1);

    state_t         state_q;
    state_t         state_d;
    logic [K_W-1:0] k_q;
    logic [SHW-1:0] shift_q;
    logic           done_q;

    logic           load_acc;
    logic           start_acc;
    logic           run_en;
    logic           last_bit;
    logic [K_W-1:0] tap_idx;
    logic           x_op_bit;
    logic           y_op_bit;
    logic           x_ovf;
    logic           y_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_acc  = 1'b0;
        start_acc = 1'b0;
        run_en    = 1'b0;
        last_bit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    load_acc = 1'b1;
                end else if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                run_en = 1'b1;
                if (k_q == K_LAST) begin
                    last_bit = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (start_acc) begin
                k_q     <= '0;
                shift_q <= shift;
            end else if (run_en) begin
                k_q <= last_bit ? '0 : k_q + K_ONE;
            end
        end
    end

    // Once the shifted bit runs past the top, keep reading the original sign bit,
    // which has rotated down to WIDTH-1-k by now.
    always_comb begin
        if (32'(k_q) + 32'(shift_q) < 32'(WIDTH)) begin
            tap_idx = K_W'(shift_q);
        end else begin
            tap_idx = K_LAST - k_q;
        end
        x_op_bit = y_out[tap_idx];
        y_op_bit = x_out[tap_idx];
    end

    serial_addsub #(.WIDTH(WIDTH)) u_x_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (load_acc),
        .load_val (x_in),
        .preset   (start_acc),
        .sub_in   (dir == DIR_SUB_X),
        .run      (run_en),
        .last     (last_bit),
        .op_bit   (x_op_bit),
        .acc      (x_out),
        .ovf      (x_ovf)
    );

    serial_addsub #(.WIDTH(WIDTH)) u_y_chan (
        .clk      (clk),
        .rst      (rst),
        .load     (load_acc),
        .load_val (y_in),
        .preset   (start_acc),
        .sub_in   (dir == DIR_ADD_X),
        .run      (run_en),
        .last     (last_bit),
        .op_bit   (y_op_bit),
        .acc      (y_out),
        .ovf      (y_ovf)
    );

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign ovf  = x_ovf | y_ovf;

endmodule
